// File: rtl/led_string_decoder.sv
// Decodes a single-wire LED serial stream back into pixel words with per-pixel
// index, frame latch detection, overflow/partial flags and pulse-width errors.
module led_string_decoder #(
  parameter int CLK_PERIOD_NS     = 50,
  parameter int DATA_WIDTH        = 24,
  parameter int N_LEDS_PER_STRING = 150,
  parameter int MIN_HIGH_NS       = 150,
  parameter int BIT_THRESHOLD_NS  = 600,
  parameter int MAX_HIGH_NS       = 1200,
  parameter int RESET_NS          = 50000
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   sdi,
  output logic [DATA_WIDTH-1:0]                  pixel_data,
  output logic                                   pixel_valid,
  output logic [$clog2(N_LEDS_PER_STRING)-1:0]   pixel_index,
  output logic                                   frame_done,
  output logic [$clog2(N_LEDS_PER_STRING+1)-1:0] frame_pixel_count,
  output logic                                   frame_overflow,
  output logic                                   frame_partial,
  output logic                                   bit_error,
  output logic                                   busy
);
  localparam int MIN_HIGH  = MIN_HIGH_NS / CLK_PERIOD_NS;
  localparam int BIT_THR   = BIT_THRESHOLD_NS / CLK_PERIOD_NS;
  localparam int MAX_HIGH  = MAX_HIGH_NS / CLK_PERIOD_NS;
  localparam int RESET_CYC = RESET_NS / CLK_PERIOD_NS;
  localparam int IDXW      = $clog2(N_LEDS_PER_STRING);
  localparam int PCW       = $clog2(N_LEDS_PER_STRING + 1);
  localparam int HCW       = $clog2(MAX_HIGH + 2);
  localparam int LCW       = $clog2(RESET_CYC + 1);
  localparam int BCW       = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {WAIT_IDLE, IDLE, HIGH, LOW} state_t;

  state_t                state_q, state_d;
  logic                  sync1_q, sync1_d, sync2_q, sync2_d, sync3_q, sync3_d;
  logic [HCW-1:0]        high_cnt_q, high_cnt_d;
  logic [LCW-1:0]        low_cnt_q, low_cnt_d;
  logic                  bit_stb_q, bit_stb_d, bit_val_q, bit_val_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [PCW-1:0]        pix_cnt_q, pix_cnt_d;
  logic                  ovf_q, ovf_d, any_bits_q, any_bits_d;
  logic [DATA_WIDTH-1:0] pixel_data_q, pixel_data_d;
  logic                  pixel_valid_q, pixel_valid_d;
  logic [IDXW-1:0]       pixel_index_q, pixel_index_d;
  logic                  frame_done_q, frame_done_d;
  logic [PCW-1:0]        frame_pixel_count_q, frame_pixel_count_d;
  logic                  frame_overflow_q, frame_overflow_d;
  logic                  frame_partial_q, frame_partial_d;
  logic                  bit_error_q, bit_error_d, busy_q, busy_d;
  logic                  rise, fall, latch;

  always_comb begin
    sync1_d = sdi;
    sync2_d = sync1_q;
    sync3_d = sync2_q;
    rise  = sync2_q & ~sync3_q;
    fall  = ~sync2_q & sync3_q;
    // Fires only on the cycle the low count reaches the limit, so never with an edge.
    latch = ~sync2_q && (low_cnt_q == LCW'(RESET_CYC - 1));

    high_cnt_d = high_cnt_q;
    if (fall)
      high_cnt_d = '0;
    else if (sync2_q && high_cnt_q != HCW'(MAX_HIGH + 1))
      high_cnt_d = high_cnt_q + 1'b1;

    low_cnt_d = low_cnt_q;
    if (rise)
      low_cnt_d = '0;
    else if (!sync2_q && low_cnt_q != LCW'(RESET_CYC))
      low_cnt_d = low_cnt_q + 1'b1;

    state_d             = state_q;
    bit_stb_d           = 1'b0;
    bit_val_d           = 1'b0;
    bit_error_d         = 1'b0;
    busy_d              = busy_q;
    frame_done_d        = 1'b0;
    frame_pixel_count_d = frame_pixel_count_q;
    frame_overflow_d    = frame_overflow_q;
    frame_partial_d     = frame_partial_q;
    shift_d             = shift_q;
    bit_cnt_d           = bit_cnt_q;
    pix_cnt_d           = pix_cnt_q;
    ovf_d               = ovf_q;
    any_bits_d          = any_bits_q;
    pixel_valid_d       = 1'b0;
    pixel_data_d        = pixel_data_q;
    pixel_index_d       = pixel_index_q;

    // Classified bits arrive one cycle after the falling edge.
    if (bit_stb_q) begin
      any_bits_d = 1'b1;
      shift_d    = {shift_q[DATA_WIDTH-2:0], bit_val_q};
      if (bit_cnt_q == BCW'(DATA_WIDTH - 1)) begin
        bit_cnt_d    = '0;
        pixel_data_d = {shift_q[DATA_WIDTH-2:0], bit_val_q};
        if (pix_cnt_q < PCW'(N_LEDS_PER_STRING)) begin
          pixel_valid_d = 1'b1;
          pixel_index_d = pix_cnt_q[IDXW-1:0];
          pix_cnt_d     = pix_cnt_q + 1'b1;
        end else begin
          ovf_d = 1'b1;
        end
      end else begin
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
    end

    unique case (state_q)
      WAIT_IDLE: if (latch) state_d = IDLE;
      IDLE: if (rise) begin
        state_d = HIGH;
        busy_d  = 1'b1;
      end
      HIGH: if (fall) begin
        state_d = LOW;
        if (high_cnt_q < HCW'(MIN_HIGH) || high_cnt_q > HCW'(MAX_HIGH)) begin
          bit_error_d = 1'b1;
        end else begin
          bit_stb_d = 1'b1;
          bit_val_d = high_cnt_q > HCW'(BIT_THR);
        end
      end
      LOW: begin
        if (rise) begin
          state_d = HIGH;
        end else if (latch) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          if (any_bits_q) begin
            frame_done_d        = 1'b1;
            frame_pixel_count_d = pix_cnt_q;
            frame_overflow_d    = ovf_q;
            frame_partial_d     = bit_cnt_q != '0;
          end
          shift_d    = '0;
          bit_cnt_d  = '0;
          pix_cnt_d  = '0;
          ovf_d      = 1'b0;
          any_bits_d = 1'b0;
        end
      end
      default: state_d = WAIT_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q             <= WAIT_IDLE;
      sync1_q             <= 1'b0;
      sync2_q             <= 1'b0;
      sync3_q             <= 1'b0;
      high_cnt_q          <= '0;
      low_cnt_q           <= '0;
      bit_stb_q           <= 1'b0;
      bit_val_q           <= 1'b0;
      shift_q             <= '0;
      bit_cnt_q           <= '0;
      pix_cnt_q           <= '0;
      ovf_q               <= 1'b0;
      any_bits_q          <= 1'b0;
      pixel_data_q        <= '0;
      pixel_valid_q       <= 1'b0;
      pixel_index_q       <= '0;
      frame_done_q        <= 1'b0;
      frame_pixel_count_q <= '0;
      frame_overflow_q    <= 1'b0;
      frame_partial_q     <= 1'b0;
      bit_error_q         <= 1'b0;
      busy_q              <= 1'b0;
    end else begin
      state_q             <= state_d;
      sync1_q             <= sync1_d;
      sync2_q             <= sync2_d;
      sync3_q             <= sync3_d;
      high_cnt_q          <= high_cnt_d;
      low_cnt_q           <= low_cnt_d;
      bit_stb_q           <= bit_stb_d;
      bit_val_q           <= bit_val_d;
      shift_q             <= shift_d;
      bit_cnt_q           <= bit_cnt_d;
      pix_cnt_q           <= pix_cnt_d;
      ovf_q               <= ovf_d;
      any_bits_q          <= any_bits_d;
      pixel_data_q        <= pixel_data_d;
      pixel_valid_q       <= pixel_valid_d;
      pixel_index_q       <= pixel_index_d;
      frame_done_q        <= frame_done_d;
      frame_pixel_count_q <= frame_pixel_count_d;
      frame_overflow_q    <= frame_overflow_d;
      frame_partial_q     <= frame_partial_d;
      bit_error_q         <= bit_error_d;
      busy_q              <= busy_d;
    end
  end

  assign pixel_data        = pixel_data_q;
  assign pixel_valid       = pixel_valid_q;
  assign pixel_index       = pixel_index_q;
  assign frame_done        = frame_done_q;
  assign frame_pixel_count = frame_pixel_count_q;
  assign frame_overflow    = frame_overflow_q;
  assign frame_partial     = frame_partial_q;
  assign bit_error         = bit_error_q;
  assign busy              = busy_q;
endmodule

// File: tb/tb_led_string_decoder.sv
// Randomized bench for led_string_decoder: sends pulse trains and compares the
// decoded pixels, errors and frame reports with a bit-stream reference model.
`timescale 1ns/1ps
module tb_led_string_decoder;
  localparam int DW    = 24;
  localparam int NLED  = 150;
  localparam int T_MIN = 150 / 50;
  localparam int T_THR = 600 / 50;
  localparam int T_MAX = 1200 / 50;

  logic        clk = 1'b0;
  logic        reset;
  logic        sdi;
  logic [23:0] pixel_data;
  logic        pixel_valid;
  logic [7:0]  pixel_index;
  logic        frame_done;
  logic [7:0]  frame_pixel_count;
  logic        frame_overflow, frame_partial, bit_error, busy;

  led_string_decoder #(
    .CLK_PERIOD_NS(50),
    .DATA_WIDTH(24),
    .N_LEDS_PER_STRING(150)
  ) dut (
    .clk(clk), .reset(reset), .sdi(sdi),
    .pixel_data(pixel_data), .pixel_valid(pixel_valid), .pixel_index(pixel_index),
    .frame_done(frame_done), .frame_pixel_count(frame_pixel_count),
    .frame_overflow(frame_overflow), .frame_partial(frame_partial),
    .bit_error(bit_error), .busy(busy)
  );

  always #25 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          widths[$];
  logic [31:0] obs_pix[$];
  logic [9:0]  obs_frm[$];
  int          obs_err = 0;
  int          err_base = 0;

  always @(negedge clk) begin
    if (pixel_valid) obs_pix.push_back({pixel_index, pixel_data});
    if (frame_done)  obs_frm.push_back({frame_pixel_count, frame_overflow, frame_partial});
    if (bit_error)   obs_err++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input int hi, input int lo);
    sdi = 1'b1;
    wait_cyc(hi);
    sdi = 1'b0;
    wait_cyc(lo);
    widths.push_back(hi);
  endtask

  task automatic send_bit(input logic b);
    if (b) pulse($urandom_range(13, 15), $urandom_range(1, 2));
    else   pulse($urandom_range(3, 4), $urandom_range(1, 2));
  endtask

  task automatic send_pixel(input logic [23:0] v);
    for (int i = 23; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic clear_obs();
    widths.delete();
    obs_pix.delete();
    obs_frm.delete();
    err_base = obs_err;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_data"}, pixel_data, 0);
    check({tag, "_pv"}, pixel_valid, 0);
    check({tag, "_idx"}, pixel_index, 0);
    check({tag, "_fd"}, frame_done, 0);
    check({tag, "_cnt"}, frame_pixel_count, 0);
    check({tag, "_flags"}, {frame_overflow, frame_partial, bit_error}, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  // Reads the recorded high widths as a bit stream and compares every report.
  task automatic verify(input string name, input logic expect_latch);
    logic [31:0] exp_pix[$];
    logic [23:0] acc = '0;
    int nb = 0, npix = 0, exp_err = 0, exp_nfrm, cnt;
    foreach (widths[k]) begin
      if (widths[k] < T_MIN || widths[k] > T_MAX) exp_err++;
      else begin
        acc = {acc[DW-2:0], widths[k] > T_THR};
        nb++;
        if (nb % DW == 0) begin
          if (npix < NLED) exp_pix.push_back({8'(npix), acc});
          npix++;
        end
      end
    end
    exp_nfrm = (expect_latch && nb > 0) ? 1 : 0;
    cnt = (npix < NLED) ? npix : NLED;
    check({name, "_npix"}, obs_pix.size(), exp_pix.size());
    for (int i = 0; i < exp_pix.size() && i < obs_pix.size(); i++)
      check({name, "_pix"}, obs_pix[i], exp_pix[i]);
    check({name, "_errs"}, obs_err - err_base, exp_err);
    check({name, "_nfrm"}, obs_frm.size(), exp_nfrm);
    if (exp_nfrm == 1 && obs_frm.size() > 0)
      check({name, "_frm"}, obs_frm[0], {8'(cnt), npix > NLED, (nb % DW) != 0});
    clear_obs();
  endtask

  initial begin
    logic [23:0] v, base;
    reset = 1'b1;
    sdi   = 1'b0;
    wait_cyc(5);
    check_zero("rst");
    reset = 1'b0;

    // Activity before the first full idle period must be ignored.
    for (int i = 0; i < 30; i++) send_bit(1'($urandom));
    pulse(2, 3);
    wait_cyc(1010);
    widths.delete();
    verify("preidle", 1'b1);

    v = 24'hA5C30F;
    for (int i = 23; i >= 1; i--) pulse(v[i] ? 16 : 8, v[i] ? 9 : 17);
    check("busy_mid", busy, 1);
    sdi = 1'b1;
    wait_cyc(16);
    widths.push_back(16);
    sdi = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("lat_early", pixel_valid, 0);
    @(posedge clk);
    @(negedge clk);
    check("lat_pv", pixel_valid, 1);
    @(posedge clk);
    #1;
    wait_cyc(1020);
    if (obs_pix.size() > 0) check("start_val", obs_pix[0], {8'd0, 24'hA5C30F});
    check("busy_idle", busy, 0);
    verify("startup", 1'b1);

    base = 24'($urandom_range(0, 1023));
    for (int i = 0; i < NLED; i++) send_pixel(base + 24'(i));
    wait_cyc(1020);
    verify("full", 1'b1);

    base = 24'($urandom_range(0, 1023));
    for (int i = 0; i < NLED + 2; i++) send_pixel(base + 24'(i));
    wait_cyc(1020);
    verify("ovf", 1'b1);

    v = 24'($urandom);
    for (int i = 23; i >= 0; i--) begin
      send_bit(v[i]);
      if (i == 18) pulse(2, 3);
      if (i == 6)  pulse(30, 3);
    end
    for (int i = 0; i < 10; i++) send_bit(1'($urandom));
    wait_cyc(1020);
    verify("err", 1'b1);

    pulse(3, 3);
    pulse(12, 3);
    pulse(13, 3);
    pulse(24, 3);
    for (int i = 0; i < 20; i++) send_bit(1'($urandom));
    pulse(25, 3);
    wait_cyc(1020);
    if (obs_pix.size() > 0) check("thr_bits", obs_pix[0][23:20], 4'b0011);
    verify("thr", 1'b1);

    // Reset mid-pixel, then a full idle is needed before decoding resumes.
    for (int i = 0; i < 10; i++) send_bit(1'($urandom));
    reset = 1'b1;
    wait_cyc(1);
    check_zero("midrst");
    wait_cyc(1);
    reset = 1'b0;
    clear_obs();
    send_pixel(24'($urandom));
    wait_cyc(1020);
    widths.delete();
    verify("postrst", 1'b1);
    send_pixel(24'($urandom));
    wait_cyc(1020);
    verify("reidle", 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/led_string_decoder.md
Name: led_string_decoder

Overview:
- Decodes the single-wire LED serial stream produced on a led_sdi line back into 24-bit pixel words, with per-pixel index and frame boundaries.
- Used as the loopback or monitor end of each string output. It lets hardware self-test and benches check string data against the frame written into the pixel FIFO.
- Classifies every high pulse by its width as a 0 or a 1, assembles bits MSB-first into DATA_WIDTH-bit pixels, and detects the low-time latch that ends a frame.

Parameters:
- CLK_PERIOD_NS, 50: clk period in ns; all timing parameters below are converted to cycles by integer division.
- DATA_WIDTH, 24: bits per pixel.
- N_LEDS_PER_STRING, 150: maximum pixels reported per frame.
- MIN_HIGH_NS, 150: high pulses shorter than this are glitches (3 cycles).
- BIT_THRESHOLD_NS, 600: a high time at or below this is a 0 bit, above it is a 1 bit (12 cycles).
- MAX_HIGH_NS, 1200: high time above this is an error (24 cycles).
- RESET_NS, 50000: low time that latches and ends a frame (1000 cycles).

Ports:
- clk, in, 1: clock.
- reset, in, 1: reset, synchronous, active-high.
- sdi, in, 1: asynchronous serial LED data line.
- pixel_data, out, DATA_WIDTH: last completed pixel, MSB = first bit received; no reordering.
- pixel_valid, out, 1: one-cycle strobe marking pixel_data and pixel_index valid.
- pixel_index, out, $clog2(N_LEDS_PER_STRING): position of the pixel within the current frame, 0-based.
- frame_done, out, 1: one-cycle strobe when the latch low time is reached after at least one bit.
- frame_pixel_count, out, $clog2(N_LEDS_PER_STRING+1): pixels completed in the frame; valid with frame_done and held until the next frame_done.
- frame_overflow, out, 1: valid with frame_done; more than N_LEDS_PER_STRING pixels were received.
- frame_partial, out, 1: valid with frame_done; the latch arrived with 1..DATA_WIDTH-1 bits pending.
- bit_error, out, 1: one-cycle strobe for a glitch or an over-long high pulse.
- busy, out, 1: high from the first rising edge of a frame until frame_done.

Behaviour:
- Reset values: all outputs 0; pixel_data 0; all counters 0; state WAIT_IDLE.
- Input handling:
  - sdi passes through 2 synchronizer flops, then a third flop for edge detection.
  - The rising and falling edge strobes are combinational from the last two flops.
- Counters:
  - high_cnt counts cycles while the synchronized sdi is high and saturates at MAX_HIGH+1.
  - low_cnt counts cycles while it is low and saturates at RESET.
  - Both counters clear on the opposite edge.
- States:
  - WAIT_IDLE: entered after reset. The line must stay low for RESET cycles to move to IDLE; any high restarts low_cnt. No outputs are produced, so the block cannot lock onto a stream mid-frame.
  - IDLE: a rising edge goes to HIGH and sets busy.
  - HIGH: on the falling edge, classify high_cnt:
    - below MIN_HIGH: pulse bit_error, discard the bit.
    - MIN_HIGH up to and including BIT_THRESHOLD: shift in 0.
    - above BIT_THRESHOLD up to and including MAX_HIGH: shift in 1.
    - above MAX_HIGH: pulse bit_error, discard the bit.
    - All four cases then go to LOW.
  - LOW: a rising edge goes to HIGH. When low_cnt reaches RESET, latch the frame and go to IDLE.
- Pixel assembly:
  - A shift register takes bits in at the LSB; bit_cnt counts 0..DATA_WIDTH-1.
  - On the DATA_WIDTH-th bit, pixel_data is loaded with the complete word, bit_cnt returns to 0 and pix_cnt increments.
  - pixel_valid pulses only if pix_cnt < N_LEDS_PER_STRING. Beyond that no pixel_valid is issued and an overflow flag is set.
- Latency: pixel_valid is high exactly 3 clk cycles after the clk edge at which the first synchronizer flop samples the sdi falling edge of the final bit.
- Latch: on the cycle low_cnt reaches RESET, with bits or pixels received in the frame:
  - pulse frame_done;
  - frame_pixel_count = min(pix_cnt, N_LEDS_PER_STRING);
  - frame_overflow and frame_partial are set from the frame's flags;
  - pending bits are discarded, all frame counters clear and busy drops.
  - A latch with no bits received produces no frame_done.
- Simultaneous events: none are possible, since the edge and latch conditions are mutually exclusive per cycle. Glitch pulses do not reset low-time tracking beyond the normal edge clearing.
- Reset mid-frame: all state is cleared, outputs go low the next cycle, and the block re-enters WAIT_IDLE.

Test Plan:
- Startup: hold sdi low for 1000 cycles, then send 1 pixel of 0xA5C30F (high 8 cycles for a 0, 16 cycles for a 1, 25-cycle bit period), then low for 1000 cycles. Required: after startup, one pixel_valid with data 0xA5C30F and index 0; then frame_done with count 1, overflow 0, partial 0.
- Full frame: send 150 pixels with incrementing values. Required: 150 pixel_valid strobes with indices 0..149 and matching data, then frame_done with count 150.
- Overflow: send 152 pixels. Required: 150 strobes, frame_done with count 150 and frame_overflow=1.
- Errors: inject a 2-cycle high pulse and a 30-cycle high pulse mid-pixel. Required: two bit_error strobes and no bits shifted. Then send a latch with 10 bits pending. Required: frame_partial=1.
- Threshold edges: send high times of 3, 12, 13 and 24 cycles. Required: bits decode as 0, 0, 1, 1. Send 25 cycles. Required: bit_error.
- Startup and reset: with sdi toggling before the 1000-cycle idle, no outputs are produced. Assert reset mid-pixel. Required: outputs go to 0 and the next output needs another full 1000-cycle idle.
